// File: rtl/spi_target_pkg.sv
// Shared constants for the SPI target: word width, sync depth and FSM encodings.
package spi_target_pkg;
    localparam int W_CPU           = 32;
    localparam int SPI_SYNC_STAGES = 2;

    localparam logic [1:0] SPI_T_IDLE  = 2'd0;
    localparam logic [1:0] SPI_T_SHIFT = 2'd1;
    localparam logic [1:0] SPI_T_ABORT = 2'd2;
endpackage

// File: rtl/spi_target_if.sv
// Word-level rx/tx handshake between the SPI target and the local device.
interface spi_target_if
    import spi_target_pkg::*;
#(
    parameter int W_WORD = W_CPU
);
    logic [W_WORD-1:0] tx_data;
    logic              tx_load;
    logic              tx_ready;
    logic [W_WORD-1:0] rx_data;
    logic              rx_dv;
    logic              rx_ack;
    logic              rx_overrun;
    logic              tx_underrun;
    logic              busy;

    modport master (
        output tx_data, tx_load, rx_ack,
        input  tx_ready, rx_data, rx_dv, rx_overrun, tx_underrun, busy
    );

    modport slave (
        input  tx_data, tx_load, rx_ack,
        output tx_ready, rx_data, rx_dv, rx_overrun, tx_underrun, busy
    );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop pin synchronizer with rise/fall pulses from the last two synchronized samples.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    sync_reg[gi] <= RST_VAL;
                else if (gi == 0)
                    sync_reg[gi] <= din;
                else
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prev_reg <= RST_VAL;
        else
            prev_reg <= sync_reg[STAGES-1];
    end

    assign sync = sync_reg[STAGES-1];
    assign rise = sync & ~prev_reg;
    assign fall = ~sync & prev_reg;
endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled pins, 32-bit MSB-first words, rx/tx holding handshake.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int W_WORD      = W_CPU,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         spi_sclk,
    input  logic         spi_cs_n,
    input  logic         spi_mosi,
    output logic         spi_miso,
    output logic         spi_miso_oe,
    spi_target_if.slave  bus
);
    localparam int CW = $clog2(W_WORD);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s;
    logic [1:0] mosi_edges_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .din(spi_sclk),
        .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    // cs_n resets high so MISO is released asynchronously and no false select is seen.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
        .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .din(spi_mosi),
        .sync(mosi_s), .rise(mosi_edges_unused[0]), .fall(mosi_edges_unused[1])
    );

    logic [1:0]        state_reg;
    logic [CW-1:0]     bit_cnt_reg;
    logic [W_WORD-1:0] rx_shift_reg, tx_shift_reg, hold_reg, rx_data_reg;
    logic              hold_full_reg, reload_pending_reg, underrun_pending_reg;
    logic              rx_dv_reg, overrun_reg, underrun_reg;

    logic start, reload, consume, capture, word_done, shifting;

    assign shifting  = (state_reg == SPI_T_SHIFT) && !cs_rise;
    assign start     = (state_reg == SPI_T_IDLE) && cs_fall;
    assign reload    = shifting && sclk_fall && reload_pending_reg;
    assign consume   = (start || reload) && hold_full_reg;
    assign capture   = bus.tx_load && (!hold_full_reg || consume);
    assign word_done = shifting && sclk_rise && (bit_cnt_reg == CW'(W_WORD-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg            <= SPI_T_IDLE;
            bit_cnt_reg          <= '0;
            rx_shift_reg         <= '0;
            tx_shift_reg         <= '0;
            hold_reg             <= '0;
            rx_data_reg          <= '0;
            hold_full_reg        <= 1'b0;
            reload_pending_reg   <= 1'b0;
            underrun_pending_reg <= 1'b0;
            rx_dv_reg            <= 1'b0;
            overrun_reg          <= 1'b0;
            underrun_reg         <= 1'b0;
        end else begin
            if (capture) begin
                hold_reg      <= bus.tx_data;
                hold_full_reg <= 1'b1;
            end else if (consume) begin
                hold_full_reg <= 1'b0;
            end

            // A new word beats a coincident ack; overrun only if the old word was still unread.
            if (word_done) begin
                rx_data_reg <= {rx_shift_reg[W_WORD-2:0], mosi_s};
                rx_dv_reg   <= 1'b1;
                if (rx_dv_reg && !bus.rx_ack)
                    overrun_reg <= 1'b1;
            end else if (bus.rx_ack) begin
                rx_dv_reg <= 1'b0;
            end

            case (state_reg)
                SPI_T_IDLE: begin
                    if (cs_fall) begin
                        state_reg            <= SPI_T_SHIFT;
                        bit_cnt_reg          <= '0;
                        tx_shift_reg         <= hold_full_reg ? hold_reg : '0;
                        reload_pending_reg   <= 1'b0;
                        underrun_pending_reg <= 1'b0;
                        if (!hold_full_reg)
                            underrun_reg <= 1'b1;
                    end
                end
                SPI_T_SHIFT: begin
                    if (cs_rise) begin
                        state_reg            <= (bit_cnt_reg != '0) ? SPI_T_ABORT : SPI_T_IDLE;
                        reload_pending_reg   <= 1'b0;
                        underrun_pending_reg <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift_reg <= {rx_shift_reg[W_WORD-2:0], mosi_s};
                        bit_cnt_reg  <= word_done ? '0 : bit_cnt_reg + 1'b1;
                        if (word_done)
                            reload_pending_reg <= 1'b1;
                        // An empty reload only counts as underrun once the next word really starts.
                        if (underrun_pending_reg) begin
                            underrun_reg         <= 1'b1;
                            underrun_pending_reg <= 1'b0;
                        end
                    end else if (sclk_fall) begin
                        if (reload_pending_reg) begin
                            tx_shift_reg         <= hold_full_reg ? hold_reg : '0;
                            reload_pending_reg   <= 1'b0;
                            underrun_pending_reg <= !hold_full_reg;
                        end else begin
                            tx_shift_reg <= {tx_shift_reg[W_WORD-2:0], 1'b0};
                        end
                    end
                end
                SPI_T_ABORT: begin
                    rx_shift_reg <= '0;
                    tx_shift_reg <= '0;
                    bit_cnt_reg  <= '0;
                    state_reg    <= SPI_T_IDLE;
                end
                default: state_reg <= SPI_T_IDLE;
            endcase
        end
    end

    assign spi_miso_oe     = ~cs_s;
    assign spi_miso        = ~cs_s & tx_shift_reg[W_WORD-1];
    assign bus.tx_ready    = ~hold_full_reg;
    assign bus.rx_data     = rx_data_reg;
    assign bus.rx_dv       = rx_dv_reg;
    assign bus.rx_overrun  = overrun_reg;
    assign bus.tx_underrun = underrun_reg;
    assign bus.busy        = (state_reg != SPI_T_IDLE);
endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI target (slave) endpoint: the far end of the CPU-side SPI master register file.
- Receives 32-bit words on MOSI and returns 32-bit words on MISO under an external SCLK/CS_n.
- Oversamples the SPI pins with the system clock and exposes a word-level rx/tx handshake to a local device model or peripheral register bank.
- Used as the bench-side peer for the CPU SPI path and as a reusable peripheral front end.

Parameters:
- W_WORD, 32 (`W_CPU): bits per transfer word, MSB first.
- SYNC_STAGES, 2: flip-flop depth of the pin synchronizers (minimum 2).

Ports:
- clk  in  1  system clock; all state is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- spi_sclk  in  1  SPI clock from the master (mode 0: CPOL=0, CPHA=0).
- spi_cs_n  in  1  chip select, active-low.
- spi_mosi  in  1  serial data from the master.
- spi_miso  out  1  serial data to the master.
- spi_miso_oe  out  1  MISO drive enable; 1 only while selected.
- tx_data  in  W_WORD  next word to transmit.
- tx_load  in  1  one-cycle strobe; captures tx_data into the holding register.
- tx_ready  out  1  holding register empty; tx_load is accepted.
- rx_data  out  W_WORD  last complete received word.
- rx_dv  out  1  rx_data valid; held until rx_ack.
- rx_ack  in  1  one-cycle strobe consuming rx_data.
- rx_overrun  out  1  sticky; a word arrived while rx_dv=1.
- tx_underrun  out  1  sticky; a word began with the holding register empty.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: all outputs 0 except tx_ready=1. Internal state is cleared: shift registers, bit counter, holding register, FSM=IDLE.
- Pin handling:
  - sclk, cs_n and mosi pass through SYNC_STAGES flops before use.
  - Rise and fall events come from the last two synchronized samples of sclk.
  - Requirement: f_sclk <= f_clk/4.
- FSM states: IDLE, SHIFT, ABORT.
- IDLE:
  - Synchronized cs_n falling -> SHIFT.
  - On entry, tx_shift loads from the holding register if full, and tx_ready returns to 1 next cycle.
  - If the holding register is empty, tx_shift loads 0 and tx_underrun is set.
  - bit_cnt=0.
- SHIFT:
  - On an sclk rise: rx_shift <= {rx_shift[W-2:0], mosi}, bit_cnt++.
  - On an sclk fall: tx_shift shifts left by 1.
  - spi_miso = tx_shift[W-1] at all times while selected, so bit 31 is valid before the first rise.
  - When the rise completing bit W-1 is detected:
    - rx_data <= completed word and rx_dv=1, one clk after the edge-detect cycle.
    - bit_cnt wraps to 0.
    - tx_shift reloads from the holding register (or 0 plus underrun) on the next fall.
    - Back-to-back words continue with no CS toggle.
- cs_n rising in SHIFT:
  - bit_cnt != 0 -> ABORT: partial word discarded, no rx_dv, rx_data unchanged.
  - bit_cnt == 0 -> IDLE.
- ABORT: one cycle, clears shift registers, -> IDLE.
- spi_miso_oe = ~cs_n_sync. spi_miso = 0 when not selected.
- rx handshake:
  - rx_dv stays 1 until rx_ack. rx_ack with rx_dv=0 is ignored.
  - New word while rx_dv=1: rx_data is overwritten and rx_overrun is set.
  - rx_ack coincident with a new word: the new word wins, rx_dv stays 1, no overrun.
- tx handshake:
  - tx_load with tx_ready=1: captures the word, tx_ready=0.
  - tx_load with tx_ready=0: ignored; the holding register is not overwritten.
  - tx_load in the same cycle the holding register is consumed: consume first, then capture. tx_ready stays 0.
- Sticky flags clear only on reset.
- Reset asserted mid-transfer: immediate return to reset values. The MISO line releases (oe=0) asynchronously.

Decomposition:
- Shared package (lib/opcodes.v style defines):
  - `W_CPU for the word width.
  - State encodings `SPI_T_IDLE/`SPI_T_SHIFT/`SPI_T_ABORT.
  - `SPI_SYNC_STAGES default.
- Sub-module spi_sync_edge:
  - Parameterised synchronizer with rise/fall pulse outputs.
  - Instantiated for sclk and cs_n. mosi uses the sync-only output.

Test Plan:
- Preload tx_data=0xCAFEF00D, master sends 0x12345678 (f_sclk=f_clk/8) -> rx_data=0x12345678, rx_dv=1; master captures 0xCAFEF00D; no flags.
- Two back-to-back words 0x00000001, 0x80000000 without rx_ack -> rx_data=0x80000000, rx_overrun=1.
- No tx preload, master sends 0xFFFFFFFF -> master receives 0x00000000, tx_underrun=1, rx_data=0xFFFFFFFF.
- CS deasserted after 13 bits of 0xA5A5A5A5 -> rx_dv stays 0, rx_data unchanged. The next full word 0x0F0F0F0F is received correctly.
- tx_load twice (0x11111111 then 0x22222222) before any transfer -> second load ignored, tx_ready=0 until CS falls, master receives 0x11111111.
- rst_n pulsed low at bit 20 -> all outputs at reset values within the same cycle, spi_miso_oe=0. A following full transfer works.
